// File: rtl/reservation_station_if.sv
// Dispatch, result-broadcast and ALU-issue bundle of the reservation station.
// The RS side uses the slave modport; whoever drives it uses master.
interface reservation_station_if #(
    parameter int ROB_POS_WIDTH = 5,
    parameter int OPENUM_WIDTH  = 6,
    parameter int DATA_WIDTH    = 32
) ();
    logic                     dispatch_enable;
    logic [OPENUM_WIDTH-1:0]  dispatch_openum;
    logic [ROB_POS_WIDTH-1:0] dispatch_rob_pos;
    logic                     dispatch_rs1_rdy;
    logic [DATA_WIDTH-1:0]    dispatch_rs1_val;
    logic [ROB_POS_WIDTH-1:0] dispatch_rs1_dep;
    logic                     dispatch_rs2_rdy;
    logic [DATA_WIDTH-1:0]    dispatch_rs2_val;
    logic [ROB_POS_WIDTH-1:0] dispatch_rs2_dep;
    logic [DATA_WIDTH-1:0]    dispatch_imm;
    logic [DATA_WIDTH-1:0]    dispatch_pc;
    logic                     rs_full;

    logic                     alu_broadcast_enable;
    logic [ROB_POS_WIDTH-1:0] alu_broadcast_rob_pos;
    logic [DATA_WIDTH-1:0]    alu_broadcast_val;
    logic                     lsb_broadcast_enable;
    logic [ROB_POS_WIDTH-1:0] lsb_broadcast_rob_pos;
    logic [DATA_WIDTH-1:0]    lsb_broadcast_val;

    logic                     rs_to_alu_enable;
    logic [OPENUM_WIDTH-1:0]  rs_to_alu_openum;
    logic [ROB_POS_WIDTH-1:0] rs_to_alu_rob_pos;
    logic [DATA_WIDTH-1:0]    rs_to_alu_rs1_val;
    logic [DATA_WIDTH-1:0]    rs_to_alu_rs2_val;
    logic [DATA_WIDTH-1:0]    rs_to_alu_imm;
    logic [DATA_WIDTH-1:0]    rs_to_alu_pc;

    modport master (
        output dispatch_enable, dispatch_openum, dispatch_rob_pos,
        output dispatch_rs1_rdy, dispatch_rs1_val, dispatch_rs1_dep,
        output dispatch_rs2_rdy, dispatch_rs2_val, dispatch_rs2_dep,
        output dispatch_imm, dispatch_pc,
        input  rs_full,
        output alu_broadcast_enable, alu_broadcast_rob_pos, alu_broadcast_val,
        output lsb_broadcast_enable, lsb_broadcast_rob_pos, lsb_broadcast_val,
        input  rs_to_alu_enable, rs_to_alu_openum, rs_to_alu_rob_pos,
        input  rs_to_alu_rs1_val, rs_to_alu_rs2_val,
        input  rs_to_alu_imm, rs_to_alu_pc
    );

    modport slave (
        input  dispatch_enable, dispatch_openum, dispatch_rob_pos,
        input  dispatch_rs1_rdy, dispatch_rs1_val, dispatch_rs1_dep,
        input  dispatch_rs2_rdy, dispatch_rs2_val, dispatch_rs2_dep,
        input  dispatch_imm, dispatch_pc,
        output rs_full,
        input  alu_broadcast_enable, alu_broadcast_rob_pos, alu_broadcast_val,
        input  lsb_broadcast_enable, lsb_broadcast_rob_pos, lsb_broadcast_val,
        output rs_to_alu_enable, rs_to_alu_openum, rs_to_alu_rob_pos,
        output rs_to_alu_rs1_val, rs_to_alu_rs2_val,
        output rs_to_alu_imm, rs_to_alu_pc
    );
endinterface

// File: rtl/reservation_station.sv
// Unified integer/branch reservation station: buffers dispatched ops,
// wakes operands from ALU/LSB broadcasts and issues one ready op per cycle.
module reservation_station #(
    parameter int RS_SIZE       = 16,
    parameter int ROB_POS_WIDTH = 5,
    parameter int OPENUM_WIDTH  = 6,
    parameter int DATA_WIDTH    = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic clr,
    reservation_station_if.slave rs_if
);
    localparam int IW = $clog2(RS_SIZE);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic                     busy;
        logic [OPENUM_WIDTH-1:0]  openum;
        logic [ROB_POS_WIDTH-1:0] rob_pos;
        logic                     rs1_rdy;
        logic [DATA_WIDTH-1:0]    rs1_val;
        logic [ROB_POS_WIDTH-1:0] rs1_dep;
        logic                     rs2_rdy;
        logic [DATA_WIDTH-1:0]    rs2_val;
        logic [ROB_POS_WIDTH-1:0] rs2_dep;
        logic [DATA_WIDTH-1:0]    imm;
        logic [DATA_WIDTH-1:0]    pc;
    } entry_t;

    entry_t ent_q [RS_SIZE];
    entry_t ent_d [RS_SIZE];
    entry_t new_ent;

    logic [CW-1:0] free_cnt;
    logic [IW-1:0] free_idx;
    logic          free_found;
    logic [IW-1:0] sel_idx;
    logic          sel_found;

    logic                     out_en_q;
    logic [OPENUM_WIDTH-1:0]  out_op_q;
    logic [ROB_POS_WIDTH-1:0] out_rob_q;
    logic [DATA_WIDTH-1:0]    out_rs1_q;
    logic [DATA_WIDTH-1:0]    out_rs2_q;
    logic [DATA_WIDTH-1:0]    out_imm_q;
    logic [DATA_WIDTH-1:0]    out_pc_q;

    // Returns {rdy, val} after snooping both result buses.
    function automatic logic [DATA_WIDTH:0] snoop(
        input logic                     r,
        input logic [DATA_WIDTH-1:0]    v,
        input logic [ROB_POS_WIDTH-1:0] d,
        input logic                     ae,
        input logic [ROB_POS_WIDTH-1:0] ap,
        input logic [DATA_WIDTH-1:0]    av,
        input logic                     le,
        input logic [ROB_POS_WIDTH-1:0] lp,
        input logic [DATA_WIDTH-1:0]    lv
    );
        logic [DATA_WIDTH:0] res;
        res = {r, v};
        if (!r) begin
            if (ae && ap == d) res = {1'b1, av};
            if (le && lp == d) res = {1'b1, lv};
        end
        return res;
    endfunction

    always_comb begin
        free_cnt   = '0;
        free_idx   = '0;
        free_found = 1'b0;
        sel_idx    = '0;
        sel_found  = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!ent_q[i].busy) begin
                free_cnt   = free_cnt + CW'(1);
                free_idx   = IW'(i);
                free_found = 1'b1;
            end
            if (ent_q[i].busy && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                sel_idx   = IW'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign rs_if.rs_full = (free_cnt <= CW'(1));

    always_comb begin
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.openum  = rs_if.dispatch_openum;
        new_ent.rob_pos = rs_if.dispatch_rob_pos;
        new_ent.rs1_dep = rs_if.dispatch_rs1_dep;
        new_ent.rs2_dep = rs_if.dispatch_rs2_dep;
        new_ent.imm     = rs_if.dispatch_imm;
        new_ent.pc      = rs_if.dispatch_pc;
        {new_ent.rs1_rdy, new_ent.rs1_val} = snoop(
            rs_if.dispatch_rs1_rdy, rs_if.dispatch_rs1_val,
            rs_if.dispatch_rs1_dep,
            rs_if.alu_broadcast_enable, rs_if.alu_broadcast_rob_pos,
            rs_if.alu_broadcast_val,
            rs_if.lsb_broadcast_enable, rs_if.lsb_broadcast_rob_pos,
            rs_if.lsb_broadcast_val);
        {new_ent.rs2_rdy, new_ent.rs2_val} = snoop(
            rs_if.dispatch_rs2_rdy, rs_if.dispatch_rs2_val,
            rs_if.dispatch_rs2_dep,
            rs_if.alu_broadcast_enable, rs_if.alu_broadcast_rob_pos,
            rs_if.alu_broadcast_val,
            rs_if.lsb_broadcast_enable, rs_if.lsb_broadcast_rob_pos,
            rs_if.lsb_broadcast_val);
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy) begin
                {ent_d[i].rs1_rdy, ent_d[i].rs1_val} = snoop(
                    ent_q[i].rs1_rdy, ent_q[i].rs1_val, ent_q[i].rs1_dep,
                    rs_if.alu_broadcast_enable, rs_if.alu_broadcast_rob_pos,
                    rs_if.alu_broadcast_val,
                    rs_if.lsb_broadcast_enable, rs_if.lsb_broadcast_rob_pos,
                    rs_if.lsb_broadcast_val);
                {ent_d[i].rs2_rdy, ent_d[i].rs2_val} = snoop(
                    ent_q[i].rs2_rdy, ent_q[i].rs2_val, ent_q[i].rs2_dep,
                    rs_if.alu_broadcast_enable, rs_if.alu_broadcast_rob_pos,
                    rs_if.alu_broadcast_val,
                    rs_if.lsb_broadcast_enable, rs_if.lsb_broadcast_rob_pos,
                    rs_if.lsb_broadcast_val);
            end
        end
        // The free slot was idle before this edge, so it never aliases the issued one.
        if (sel_found) ent_d[sel_idx].busy = 1'b0;
        if (rs_if.dispatch_enable && free_found) ent_d[free_idx] = new_ent;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
            out_en_q  <= 1'b0;
            out_op_q  <= '0;
            out_rob_q <= '0;
            out_rs1_q <= '0;
            out_rs2_q <= '0;
            out_imm_q <= '0;
            out_pc_q  <= '0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
            out_en_q <= sel_found;
            if (sel_found) begin
                out_op_q  <= ent_q[sel_idx].openum;
                out_rob_q <= ent_q[sel_idx].rob_pos;
                out_rs1_q <= ent_q[sel_idx].rs1_val;
                out_rs2_q <= ent_q[sel_idx].rs2_val;
                out_imm_q <= ent_q[sel_idx].imm;
                out_pc_q  <= ent_q[sel_idx].pc;
            end
        end
    end

    assign rs_if.rs_to_alu_enable  = out_en_q;
    assign rs_if.rs_to_alu_openum  = out_op_q;
    assign rs_if.rs_to_alu_rob_pos = out_rob_q;
    assign rs_if.rs_to_alu_rs1_val = out_rs1_q;
    assign rs_if.rs_to_alu_rs2_val = out_rs2_q;
    assign rs_if.rs_to_alu_imm     = out_imm_q;
    assign rs_if.rs_to_alu_pc      = out_pc_q;

    a_no_dispatch_when_full: assert property (
        @(posedge clk) disable iff (rst)
        (rdy && !clr && rs_if.dispatch_enable) |-> (free_cnt != '0));

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue latency, wakeup, bypass,
// full back-pressure, index priority, flush and rdy freeze.
module tb_reservation_station;
    localparam int RW = 5;
    localparam int OW = 6;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic clr = 1'b0;

    int total = 0;
    int bad   = 0;

    reservation_station_if #(
        .ROB_POS_WIDTH(RW), .OPENUM_WIDTH(OW), .DATA_WIDTH(DW)
    ) rs_if ();

    reservation_station #(
        .RS_SIZE(16), .ROB_POS_WIDTH(RW), .OPENUM_WIDTH(OW), .DATA_WIDTH(DW)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clr   (clr),
        .rs_if (rs_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [OW-1:0] op, input logic [RW-1:0] rob,
                            input logic r1, input logic [DW-1:0] v1,
                            input logic [RW-1:0] d1,
                            input logic r2, input logic [DW-1:0] v2,
                            input logic [RW-1:0] d2);
        rs_if.dispatch_enable  = 1'b1;
        rs_if.dispatch_openum  = op;
        rs_if.dispatch_rob_pos = rob;
        rs_if.dispatch_rs1_rdy = r1;
        rs_if.dispatch_rs1_val = v1;
        rs_if.dispatch_rs1_dep = d1;
        rs_if.dispatch_rs2_rdy = r2;
        rs_if.dispatch_rs2_val = v2;
        rs_if.dispatch_rs2_dep = d2;
        rs_if.dispatch_imm     = 32'h100 + 32'(rob);
        rs_if.dispatch_pc      = 32'h1000 + 32'(rob) * 4;
    endtask

    task automatic idle_bus();
        rs_if.dispatch_enable      = 1'b0;
        rs_if.alu_broadcast_enable = 1'b0;
        rs_if.lsb_broadcast_enable = 1'b0;
    endtask

    initial begin
        idle_bus();
        set_disp('0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        rs_if.dispatch_enable       = 1'b0;
        rs_if.alu_broadcast_rob_pos = '0;
        rs_if.alu_broadcast_val     = '0;
        rs_if.lsb_broadcast_rob_pos = '0;
        rs_if.lsb_broadcast_val     = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_en", 32'(rs_if.rs_to_alu_enable), 0);
        chk("rst_full", 32'(rs_if.rs_full), 0);

        // ADD with both operands ready
        set_disp(6'd1, 5'd3, 1'b1, 32'd5, '0, 1'b1, 32'd7, '0);
        tick();
        idle_bus();
        chk("add_en_n", 32'(rs_if.rs_to_alu_enable), 0);
        tick();
        chk("add_en", 32'(rs_if.rs_to_alu_enable), 1);
        chk("add_op", 32'(rs_if.rs_to_alu_openum), 1);
        chk("add_rob", 32'(rs_if.rs_to_alu_rob_pos), 3);
        chk("add_rs1", rs_if.rs_to_alu_rs1_val, 5);
        chk("add_rs2", rs_if.rs_to_alu_rs2_val, 7);
        chk("add_imm", rs_if.rs_to_alu_imm, 32'h103);
        chk("add_pc", rs_if.rs_to_alu_pc, 32'h100c);
        tick();
        chk("add_en_off", 32'(rs_if.rs_to_alu_enable), 0);

        // SUB waiting on ALU result for rob 2
        set_disp(6'd2, 5'd4, 1'b1, 32'd9, '0, 1'b0, '0, 5'd2);
        tick();
        idle_bus();
        chk("sub_wait0", 32'(rs_if.rs_to_alu_enable), 0);
        tick();
        chk("sub_wait1", 32'(rs_if.rs_to_alu_enable), 0);
        tick();
        chk("sub_wait2", 32'(rs_if.rs_to_alu_enable), 0);
        rs_if.alu_broadcast_enable  = 1'b1;
        rs_if.alu_broadcast_rob_pos = 5'd2;
        rs_if.alu_broadcast_val     = 32'h10;
        tick();
        idle_bus();
        chk("sub_wake_edge", 32'(rs_if.rs_to_alu_enable), 0);
        tick();
        chk("sub_en", 32'(rs_if.rs_to_alu_enable), 1);
        chk("sub_rob", 32'(rs_if.rs_to_alu_rob_pos), 4);
        chk("sub_rs1", rs_if.rs_to_alu_rs1_val, 9);
        chk("sub_rs2", rs_if.rs_to_alu_rs2_val, 32'h10);

        // dispatch bypass from LSB broadcast
        set_disp(6'd3, 5'd7, 1'b0, '0, 5'd6, 1'b1, 32'd1, '0);
        rs_if.lsb_broadcast_enable  = 1'b1;
        rs_if.lsb_broadcast_rob_pos = 5'd6;
        rs_if.lsb_broadcast_val     = 32'hABCD;
        tick();
        idle_bus();
        chk("byp_en_n", 32'(rs_if.rs_to_alu_enable), 0);
        tick();
        chk("byp_en", 32'(rs_if.rs_to_alu_enable), 1);
        chk("byp_rob", 32'(rs_if.rs_to_alu_rob_pos), 7);
        chk("byp_rs1", rs_if.rs_to_alu_rs1_val, 32'hABCD);
        tick();
        chk("byp_en_off", 32'(rs_if.rs_to_alu_enable), 0);

        // fill all 16 slots with never-ready ops
        for (int i = 0; i < 16; i++) begin
            set_disp(6'd4, 5'(i), 1'b0, '0, 5'(16 + i), 1'b1, 32'd2, '0);
            tick();
            idle_bus();
            if (i == 13) chk("full_14", 32'(rs_if.rs_full), 0);
            if (i == 14) chk("full_15", 32'(rs_if.rs_full), 1);
        end
        chk("full_16", 32'(rs_if.rs_full), 1);
        chk("full_noiss", 32'(rs_if.rs_to_alu_enable), 0);
        rs_if.alu_broadcast_enable  = 1'b1;
        rs_if.alu_broadcast_rob_pos = 5'd16;
        rs_if.alu_broadcast_val     = 32'h55;
        tick();
        idle_bus();
        chk("full_wake_en", 32'(rs_if.rs_to_alu_enable), 0);
        tick();
        chk("full_iss0_en", 32'(rs_if.rs_to_alu_enable), 1);
        chk("full_iss0_rob", 32'(rs_if.rs_to_alu_rob_pos), 0);
        chk("full_iss0_rs1", rs_if.rs_to_alu_rs1_val, 32'h55);
        chk("full_free1", 32'(rs_if.rs_full), 1);
        rs_if.alu_broadcast_enable  = 1'b1;
        rs_if.alu_broadcast_rob_pos = 5'd17;
        rs_if.alu_broadcast_val     = 32'h66;
        tick();
        idle_bus();
        chk("full_gap_en", 32'(rs_if.rs_to_alu_enable), 0);
        tick();
        chk("full_iss1_rob", 32'(rs_if.rs_to_alu_rob_pos), 1);
        chk("full_free2", 32'(rs_if.rs_full), 0);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr1_full", 32'(rs_if.rs_full), 0);

        // idx 2 and 5 wake together
        for (int i = 0; i < 6; i++) begin
            set_disp(6'd5, 5'(8 + i), 1'b0, '0, 5'(10 + i), 1'b1, '0, '0);
            tick();
            idle_bus();
        end
        rs_if.alu_broadcast_enable  = 1'b1;
        rs_if.alu_broadcast_rob_pos = 5'd12;
        rs_if.alu_broadcast_val     = 32'hA2;
        rs_if.lsb_broadcast_enable  = 1'b1;
        rs_if.lsb_broadcast_rob_pos = 5'd15;
        rs_if.lsb_broadcast_val     = 32'hB5;
        tick();
        idle_bus();
        chk("pri_wake_en", 32'(rs_if.rs_to_alu_enable), 0);
        tick();
        chk("pri_first_rob", 32'(rs_if.rs_to_alu_rob_pos), 10);
        chk("pri_first_rs1", rs_if.rs_to_alu_rs1_val, 32'hA2);
        tick();
        chk("pri_second_en", 32'(rs_if.rs_to_alu_enable), 1);
        chk("pri_second_rob", 32'(rs_if.rs_to_alu_rob_pos), 13);
        chk("pri_second_rs1", rs_if.rs_to_alu_rs1_val, 32'hB5);
        tick();
        chk("pri_done", 32'(rs_if.rs_to_alu_enable), 0);

        // 8 busy, then flush with an in-flight ready dispatch
        for (int i = 0; i < 4; i++) begin
            set_disp(6'd6, 5'(20 + i), 1'b0, '0, 5'(20 + i), 1'b1, '0, '0);
            tick();
            idle_bus();
        end
        set_disp(6'd7, 5'd7, 1'b1, 32'd1, '0, 1'b1, 32'd2, '0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        idle_bus();
        chk("clr_en", 32'(rs_if.rs_to_alu_enable), 0);
        chk("clr_rob", 32'(rs_if.rs_to_alu_rob_pos), 0);
        chk("clr_rs1", rs_if.rs_to_alu_rs1_val, 0);
        chk("clr_full", 32'(rs_if.rs_full), 0);
        rs_if.alu_broadcast_enable  = 1'b1;
        rs_if.alu_broadcast_rob_pos = 5'd10;
        rs_if.lsb_broadcast_enable  = 1'b1;
        rs_if.lsb_broadcast_rob_pos = 5'd20;
        tick();
        idle_bus();
        chk("clr_post0", 32'(rs_if.rs_to_alu_enable), 0);
        tick();
        chk("clr_post1", 32'(rs_if.rs_to_alu_enable), 0);

        // rdy freeze
        set_disp(6'd8, 5'd9, 1'b1, 32'h77, '0, 1'b1, 32'h88, '0);
        tick();
        idle_bus();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_noiss", 32'(rs_if.rs_to_alu_enable), 0);
        end
        rdy = 1'b1;
        tick();
        chk("frz_en", 32'(rs_if.rs_to_alu_enable), 1);
        chk("frz_rob", 32'(rs_if.rs_to_alu_rob_pos), 9);
        chk("frz_rs2", rs_if.rs_to_alu_rs2_val, 32'h88);
        rdy = 1'b0;
        tick();
        chk("frz_hold_en", 32'(rs_if.rs_to_alu_enable), 1);
        chk("frz_hold_rob", 32'(rs_if.rs_to_alu_rob_pos), 9);
        rdy = 1'b1;
        tick();
        chk("frz_rel_en", 32'(rs_if.rs_to_alu_enable), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
